// File: rtl/memulator_pkg.sv
// Shared types for the bank command sequencer.
//   cmd_e       : command encoding on the cmd port (6 and 7 are illegal)
//   seq_state_e : sequencer FSM states
//   BL / BC     : full burst length and burst-chop length in beats
package memulator_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    PREA = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } seq_state_e;

  localparam int BL = 8;
  localparam int BC = 4;

endpackage

// File: rtl/bank_state_table.sv
// Per-bank open flag and open-row register.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   open_en            : open bank (bg,ba) and latch row_in as its row
//   close_en           : close bank (bg,ba); closing a closed bank is harmless
//   close_all          : close every bank
//   bg, ba, row_in     : target bank address and row for open_en
//   is_open[bg][ba]    : bank open flags
//   row[bg][ba]        : last row opened in each bank (kept after close)
module bank_state_table
  import memulator_pkg::*;
#(
  parameter int BGWIDTH       = 2,
  parameter int BANKGROUPS    = 2**BGWIDTH,
  parameter int BAWIDTH       = 2,
  parameter int BANKSPERGROUP = 2**BAWIDTH,
  parameter int CHWIDTH       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               open_en,
  input  logic               close_en,
  input  logic               close_all,
  input  logic [BGWIDTH-1:0] bg,
  input  logic [BAWIDTH-1:0] ba,
  input  logic [CHWIDTH-1:0] row_in,
  output logic               is_open [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
  output logic [CHWIDTH-1:0] row     [BANKGROUPS-1:0][BANKSPERGROUP-1:0]
);

  logic               open_q [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic               open_d [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic [CHWIDTH-1:0] row_q  [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic [CHWIDTH-1:0] row_d  [BANKGROUPS-1:0][BANKSPERGROUP-1:0];

  // Close has priority over open; the sequencer never asserts both for one bank.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        if (close_all || (close_en && (BGWIDTH'(g) == bg) && (BAWIDTH'(b) == ba))) begin
          open_d[g][b] = 1'b0;
        end else if (open_en && (BGWIDTH'(g) == bg) && (BAWIDTH'(b) == ba)) begin
          open_d[g][b] = 1'b1;
          row_d[g][b]  = row_in;
        end
      end
    end
  end

  // Bank state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          open_q[g][b] <= 1'b0;
          row_q[g][b]  <= '0;
        end
      end
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  assign is_open = open_q;
  assign row     = row_q;

endmodule

// File: rtl/bank_cmd_sequencer.sv
// DDR-style command front end for Chip. Accepts ACT/RD/WR/PRE/PREA, tracks open rows,
// times CL/CWL and steps 8-beat (or chopped 4-beat) bursts with wrapped column order.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake (ready only in IDLE, never in reset)
//   cmd, cmd_bg, cmd_ba,
//   cmd_row, cmd_col         : command and its address fields
//   cmd_bc                   : burst chop request (only when BURST_CHOP_EN is defined)
//   wr_req / wr_data         : write data request, data sampled on the next edge
//   rd_valid / rd_data       : read beat return
//   err                      : one-cycle pulse on an illegal command
//   rd_o_wr, dqin, row,
//   column, dqout            : per-bank arrays to/from Chip (rd_o_wr=1 means write)
// Optional feature macro: BURST_CHOP_EN
module bank_cmd_sequencer
  import memulator_pkg::*;
#(
  parameter int BGWIDTH       = 2,
  parameter int BANKGROUPS    = 2**BGWIDTH,
  parameter int BAWIDTH       = 2,
  parameter int BANKSPERGROUP = 2**BAWIDTH,
  parameter int COLWIDTH      = 10,
  parameter int CHWIDTH       = 5,
  parameter int DEVICE_WIDTH  = 4,
  parameter int CL            = 5,
  parameter int CWL           = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd,
  input  logic [BGWIDTH-1:0]      cmd_bg,
  input  logic [BAWIDTH-1:0]      cmd_ba,
  input  logic [CHWIDTH-1:0]      cmd_row,
  input  logic [COLWIDTH-1:0]     cmd_col,
`ifdef BURST_CHOP_EN
  input  logic                    cmd_bc,
`endif
  output logic                    wr_req,
  input  logic [DEVICE_WIDTH-1:0] wr_data,
  output logic                    rd_valid,
  output logic [DEVICE_WIDTH-1:0] rd_data,
  output logic                    err,
  output logic                    rd_o_wr [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
  output logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
  output logic [CHWIDTH-1:0]      row     [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
  output logic [COLWIDTH-1:0]     column  [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
  input  logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS-1:0][BANKSPERGROUP-1:0]
);

  localparam int MAX_LAT = (CL > CWL) ? CL : CWL;
  localparam int CNT_W   = $clog2(MAX_LAT + BL + 1) + 1;

  // Cycle indices (relative to the accept edge) of the first beat of each activity.
  localparam logic [CNT_W-1:0] RD_COL_FIRST   = CNT_W'(CL - 2);
  localparam logic [CNT_W-1:0] RD_VALID_FIRST = CNT_W'(CL);
  localparam logic [CNT_W-1:0] WR_REQ_FIRST   = CNT_W'(CWL - 1);
  localparam logic [CNT_W-1:0] WR_FIRST       = CNT_W'(CWL);

  seq_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BGWIDTH-1:0]        tgt_bg_q, tgt_bg_d;
  logic [BAWIDTH-1:0]        tgt_ba_q, tgt_ba_d;
  logic [COLWIDTH-1:0]       col_q, col_d;
  logic                      is_wr_q, is_wr_d;
  logic                      chop_q, chop_d;
  logic                      wr_req_q, wr_req_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      err_q, err_d;
  logic [DEVICE_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                      rd_o_wr_q [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic                      rd_o_wr_d [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic [DEVICE_WIDTH-1:0]   dqin_q    [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic [DEVICE_WIDTH-1:0]   dqin_d    [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic [COLWIDTH-1:0]       column_q  [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic [COLWIDTH-1:0]       column_d  [BANKGROUPS-1:0][BANKSPERGROUP-1:0];

  logic                      is_open [BANKGROUPS-1:0][BANKSPERGROUP-1:0];
  logic                      chop_in;
  logic                      accept, tgt_open, is_burst_cmd, start;
  logic                      open_en, close_en, close_all;
  logic [CNT_W-1:0]          bl_m1, first_cnt, end_cnt;
  logic                      busy_d;
  logic                      rd_col_on, rd_val_on, wr_req_on, wr_on;
  logic [2:0]                beat;
  logic [COLWIDTH-1:0]       beat_col;

`ifdef BURST_CHOP_EN
  assign chop_in = cmd_bc;
`else
  assign chop_in = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE) && !rst;

  bank_state_table #(
    .BGWIDTH      (BGWIDTH),
    .BANKGROUPS   (BANKGROUPS),
    .BAWIDTH      (BAWIDTH),
    .BANKSPERGROUP(BANKSPERGROUP),
    .CHWIDTH      (CHWIDTH)
  ) u_banks (
    .clk      (clk),
    .rst      (rst),
    .open_en  (open_en),
    .close_en (close_en),
    .close_all(close_all),
    .bg       (cmd_bg),
    .ba       (cmd_ba),
    .row_in   (cmd_row),
    .is_open  (is_open),
    .row      (row)
  );

  // True when cycle n falls inside the beat window starting at first.
  function automatic logic in_window(input logic [CNT_W-1:0] n,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] len_m1);
    return (n >= first) && ((n - first) <= len_m1);
  endfunction

  // Command decode: legality against the bank table, bank strobes and burst start.
  always_comb begin
    accept       = cmd_valid && cmd_ready;
    tgt_open     = is_open[cmd_bg][cmd_ba];
    is_burst_cmd = (cmd == RD) || (cmd == WR);
    start        = accept && is_burst_cmd && tgt_open;
    open_en      = accept && (cmd == ACT) && !tgt_open;
    close_en     = accept && (cmd == PRE);
    close_all    = accept && (cmd == PREA);
    err_d        = accept && (((cmd == ACT) && tgt_open) ||
                              (is_burst_cmd && !tgt_open) ||
                              (cmd > PREA));
  end

  // Burst context and FSM. cnt_d is the index of the cycle that begins after this edge,
  // so every registered output below is computed for exactly that cycle.
  always_comb begin
    tgt_bg_d = tgt_bg_q;
    tgt_ba_d = tgt_ba_q;
    col_d    = col_q;
    is_wr_d  = is_wr_q;
    chop_d   = chop_q;
    cnt_d    = cnt_q;
    if (start) begin
      tgt_bg_d = cmd_bg;
      tgt_ba_d = cmd_ba;
      col_d    = cmd_col;
      is_wr_d  = (cmd == WR);
      chop_d   = chop_in;
      cnt_d    = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    bl_m1     = chop_d ? CNT_W'(BC - 1) : CNT_W'(BL - 1);
    first_cnt = is_wr_d ? WR_REQ_FIRST : RD_COL_FIRST;
    end_cnt   = (is_wr_d ? WR_FIRST : RD_VALID_FIRST) + bl_m1 + 1'b1;

    state_d = state_q;
    if (start || (state_q != IDLE)) begin
      if (cnt_d == end_cnt) begin
        state_d = IDLE;
      end else if (cnt_d >= first_cnt) begin
        state_d = BURST;
      end else begin
        state_d = WAIT;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // Beat windows, wrapped column generation and steering to the target bank only.
  always_comb begin
    rd_col_on = busy_d && !is_wr_d && in_window(cnt_d, RD_COL_FIRST, bl_m1);
    rd_val_on = busy_d && !is_wr_d && in_window(cnt_d, RD_VALID_FIRST, bl_m1);
    wr_req_on = busy_d && is_wr_d && in_window(cnt_d, WR_REQ_FIRST, bl_m1);
    wr_on     = busy_d && is_wr_d && in_window(cnt_d, WR_FIRST, bl_m1);

    beat = is_wr_d ? 3'(cnt_d - WR_FIRST) : 3'(cnt_d - RD_COL_FIRST);
    if (chop_d) begin
      beat_col = {col_d[COLWIDTH-1:2], col_d[1:0] + beat[1:0]};
    end else begin
      beat_col = {col_d[COLWIDTH-1:3], col_d[2:0] + beat};
    end

    wr_req_d   = wr_req_on;
    rd_valid_d = rd_val_on;
    rd_data_d  = rd_val_on ? dqout[tgt_bg_d][tgt_ba_d] : '0;

    column_d = column_q;
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        rd_o_wr_d[g][b] = 1'b0;
        dqin_d[g][b]    = '0;
        if ((BGWIDTH'(g) == tgt_bg_d) && (BAWIDTH'(b) == tgt_ba_d)) begin
          if (rd_col_on || wr_on) begin
            column_d[g][b] = beat_col;
          end
          if (wr_on) begin
            rd_o_wr_d[g][b] = 1'b1;
            dqin_d[g][b]    = wr_data;
          end
        end
      end
    end
  end

  // All sequencer state; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tgt_bg_q   <= '0;
      tgt_ba_q   <= '0;
      col_q      <= '0;
      is_wr_q    <= 1'b0;
      chop_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          rd_o_wr_q[g][b] <= 1'b0;
          dqin_q[g][b]    <= '0;
          column_q[g][b]  <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_bg_q   <= tgt_bg_d;
      tgt_ba_q   <= tgt_ba_d;
      col_q      <= col_d;
      is_wr_q    <= is_wr_d;
      chop_q     <= chop_d;
      wr_req_q   <= wr_req_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_o_wr_q  <= rd_o_wr_d;
      dqin_q     <= dqin_d;
      column_q   <= column_d;
    end
  end

  assign wr_req   = wr_req_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;
  assign rd_o_wr  = rd_o_wr_q;
  assign dqin     = dqin_q;
  assign column   = column_q;

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Directed testbench for bank_cmd_sequencer with a small Chip model
// (one-cycle read latency, write on the edge after the strobe cycle).
// Optional feature macro: BURST_CHOP_EN (enables the burst-chop step).
module tb_bank_cmd_sequencer;
  import memulator_pkg::*;

  localparam int CL  = 5;
  localparam int CWL = 4;

  localparam logic [9:0] RD1_COLS [8] = '{10'h3FA, 10'h3FB, 10'h3FC, 10'h3FD,
                                          10'h3FE, 10'h3FF, 10'h3F8, 10'h3F9};
  localparam logic [3:0] RD1_DATA [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h9};

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [1:0] cmd_bg;
  logic [1:0] cmd_ba;
  logic [4:0] cmd_row;
  logic [9:0] cmd_col;
`ifdef BURST_CHOP_EN
  logic       cmd_bc;
`endif
  logic       wr_req;
  logic [3:0] wr_data;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       err;
  logic       rd_o_wr [3:0][3:0];
  logic [3:0] dqin    [3:0][3:0];
  logic [4:0] row     [3:0][3:0];
  logic [9:0] column  [3:0][3:0];
  logic [3:0] dqout   [3:0][3:0];

  logic [3:0] mem [4][4][1024];
  int checks = 0;
  int errors = 0;
  logic any_wr;

  always #5 clk = ~clk;

  bank_cmd_sequencer #(
    .BGWIDTH(2), .BAWIDTH(2), .COLWIDTH(10), .CHWIDTH(5),
    .DEVICE_WIDTH(4), .CL(CL), .CWL(CWL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .cmd_bg   (cmd_bg),
    .cmd_ba   (cmd_ba),
    .cmd_row  (cmd_row),
    .cmd_col  (cmd_col),
`ifdef BURST_CHOP_EN
    .cmd_bc   (cmd_bc),
`endif
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .err      (err),
    .rd_o_wr  (rd_o_wr),
    .dqin     (dqin),
    .row      (row),
    .column   (column),
    .dqout    (dqout)
  );

  // Chip model: memory preloaded with the low nibble of each column on reset,
  // written when rd_o_wr is high, read back one cycle after the column is presented.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        if (rst) begin
          for (int c = 0; c < 1024; c++) mem[g][b][c] <= 4'(c);
          dqout[g][b] <= '0;
        end else begin
          if (rd_o_wr[g][b]) mem[g][b][column[g][b]] <= dqin[g][b];
          dqout[g][b] <= mem[g][b][column[g][b]];
        end
      end
    end
  end

  // OR of every bank write strobe.
  always_comb begin
    any_wr = 1'b0;
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++)
        any_wr = any_wr | rd_o_wr[g][b];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single accepting edge, then returns in cycle 0.
  task automatic applyStimulus(input logic [2:0] c, input logic [1:0] bg, input logic [1:0] ba,
                               input logic [4:0] r, input logic [9:0] col);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_bg    = bg;
    cmd_ba    = ba;
    cmd_row   = r;
    cmd_col   = col;
    tick();
    cmd_valid = 1'b0;
    cmd       = NOP;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = NOP;
    cmd_bg    = '0;
    cmd_ba    = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    wr_data   = '0;
`ifdef BURST_CHOP_EN
    cmd_bc    = 1'b0;
`endif

    $display("[TB] reset");
    repeat (3) tick();
    checkOutput("rst_ready", cmd_ready, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_req", wr_req, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_row", row[1][2], 0);
    checkOutput("rst_col", column[1][2], 0);
    checkOutput("rst_strobe", any_wr, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", cmd_ready, 1);

    $display("[TB] test 1: wrapped 8-beat read");
    applyStimulus(ACT, 2'd1, 2'd2, 5'd5, 10'h000);
    checkOutput("act1_err", err, 0);
    checkOutput("act1_row", row[1][2], 5);
    applyStimulus(RD, 2'd1, 2'd2, 5'd0, 10'h3FA);
    for (int n = 0; n <= CL + 8; n++) begin
      checkOutput("rd1_valid", rd_valid, (n >= CL) && (n <= CL + 7));
      if ((n >= CL) && (n <= CL + 7)) checkOutput("rd1_data", rd_data, RD1_DATA[n - CL]);
      if (n < CL - 2) checkOutput("rd1_col", column[1][2], 10'h000);
      else if (n <= CL + 5) checkOutput("rd1_col", column[1][2], RD1_COLS[n - (CL - 2)]);
      else checkOutput("rd1_col_hold", column[1][2], 10'h3F9);
      checkOutput("rd1_ready", cmd_ready, n == CL + 8);
      if (n < CL + 8) tick();
    end

    $display("[TB] test 2: write then read back");
    applyStimulus(ACT, 2'd0, 2'd0, 5'd3, 10'h000);
    applyStimulus(WR, 2'd0, 2'd0, 5'd0, 10'h010);
    for (int n = 0; n <= CWL + 8; n++) begin
      checkOutput("wr2_req", wr_req, (n >= CWL - 1) && (n <= CWL + 6));
      checkOutput("wr2_strobe", rd_o_wr[0][0], (n >= CWL) && (n <= CWL + 7));
      if ((n >= CWL) && (n <= CWL + 7)) begin
        checkOutput("wr2_dqin", dqin[0][0], n - CWL + 1);
        checkOutput("wr2_col", column[0][0], 10'h010 + n - CWL);
      end
      if (n == CWL + 2) begin
        checkOutput("wr2_other_strobe", rd_o_wr[1][2], 0);
        checkOutput("wr2_other_dqin", dqin[1][2], 0);
      end
      checkOutput("wr2_ready", cmd_ready, n == CWL + 8);
      wr_data = ((n >= CWL - 1) && (n <= CWL + 6)) ? 4'(n - CWL + 2) : 4'h0;
      if (n < CWL + 8) tick();
    end
    wr_data = '0;
    applyStimulus(RD, 2'd0, 2'd0, 5'd0, 10'h010);
    for (int n = 0; n <= CL + 8; n++) begin
      checkOutput("rd2_valid", rd_valid, (n >= CL) && (n <= CL + 7));
      if ((n >= CL) && (n <= CL + 7)) checkOutput("rd2_data", rd_data, n - CL + 1);
      if (n < CL + 8) tick();
    end

    $display("[TB] test 3: read to closed bank and illegal command");
    checkOutput("rd3_ready_before", cmd_ready, 1);
    applyStimulus(RD, 2'd2, 2'd1, 5'd0, 10'h000);
    checkOutput("rd3_err", err, 1);
    checkOutput("rd3_ready", cmd_ready, 1);
    for (int n = 1; n <= CL + 3; n++) begin
      tick();
      checkOutput("rd3_no_valid", rd_valid, 0);
      checkOutput("rd3_err_low", err, 0);
    end
    applyStimulus(3'd7, 2'd0, 2'd0, 5'd0, 10'h000);
    checkOutput("ill_err", err, 1);
    tick();
    checkOutput("ill_err_low", err, 0);

    $display("[TB] test 4: ACT to open bank, PRE, PREA");
    applyStimulus(ACT, 2'd1, 2'd2, 5'd9, 10'h000);
    checkOutput("act4_err", err, 1);
    checkOutput("act4_row_kept", row[1][2], 5);
    applyStimulus(PRE, 2'd3, 2'd3, 5'd0, 10'h000);
    checkOutput("pre_closed_err", err, 0);
    applyStimulus(PREA, 2'd0, 2'd0, 5'd0, 10'h000);
    checkOutput("prea_err", err, 0);
    checkOutput("prea_row_hold", row[1][2], 5);
    applyStimulus(ACT, 2'd1, 2'd2, 5'd9, 10'h000);
    checkOutput("act4b_err", err, 0);
    checkOutput("act4b_row", row[1][2], 9);

    $display("[TB] test 5: reset in the middle of a write burst");
    applyStimulus(ACT, 2'd0, 2'd0, 5'd1, 10'h000);
    applyStimulus(WR, 2'd0, 2'd0, 5'd0, 10'h020);
    for (int n = 0; n < 7; n++) begin
      wr_data = (n >= CWL - 1) ? 4'(n - CWL + 2) : 4'h0;
      tick();
    end
    checkOutput("wr5_req_c7", wr_req, 1);
    checkOutput("wr5_strobe_c7", rd_o_wr[0][0], 1);
    rst = 1'b1;
    #1;
    checkOutput("wr5_ready_in_rst", cmd_ready, 0);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      checkOutput("wr5_no_req", wr_req, 0);
      checkOutput("wr5_no_strobe", any_wr, 0);
      checkOutput("wr5_no_valid", rd_valid, 0);
      tick();
    end
    wr_data = '0;
    applyStimulus(RD, 2'd0, 2'd0, 5'd0, 10'h020);
    checkOutput("rd5_err", err, 1);

`ifdef BURST_CHOP_EN
    $display("[TB] test 6: burst chop read");
    tick();
    applyStimulus(ACT, 2'd2, 2'd1, 5'd2, 10'h000);
    cmd_bc = 1'b1;
    applyStimulus(RD, 2'd2, 2'd1, 5'd0, 10'h006);
    cmd_bc = 1'b0;
    for (int n = 0; n <= CL + 5; n++) begin
      checkOutput("bc_valid", rd_valid, (n >= CL) && (n <= CL + 3));
      if (n == CL)     checkOutput("bc_data0", rd_data, 4'h6);
      if (n == CL + 1) checkOutput("bc_data1", rd_data, 4'h7);
      if (n == CL + 2) checkOutput("bc_data2", rd_data, 4'h4);
      if (n == CL + 3) checkOutput("bc_data3", rd_data, 4'h5);
      if (n == CL - 2) checkOutput("bc_col0", column[2][1], 10'h006);
      if (n == CL - 1) checkOutput("bc_col1", column[2][1], 10'h007);
      if (n == CL)     checkOutput("bc_col2", column[2][1], 10'h004);
      if (n == CL + 1) checkOutput("bc_col3", column[2][1], 10'h005);
      checkOutput("bc_ready", cmd_ready, n >= CL + 4);
      if (n < CL + 5) tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
